// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pooling stage: reduces non-overlapping POOLW-sample windows of each
// LEN-sample vector to their signed maximum and emits them via a 2-entry output buffer.
module maxpool_stream #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEN    = 5,
  parameter int unsigned POOLW  = 2,
  parameter int unsigned LOGLEN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    m_last_z
);

  localparam logic [LOGLEN-1:0] LastIdx = LOGLEN'(LEN - 1);
  localparam logic [LOGLEN-1:0] WinLast = LOGLEN'(POOLW - 1);

  logic [LOGLEN-1:0]       in_cnt_q, in_cnt_d;
  logic [LOGLEN-1:0]       win_cnt_q, win_cnt_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic signed [WIDTH-1:0] fifo_data_q [2];
  logic signed [WIDTH-1:0] fifo_data_d [2];
  logic                    fifo_last_q [2];
  logic                    fifo_last_d [2];
  logic [1:0]              count_q, count_d;

  logic                    accept, pop, push, vec_end, win_close;
  logic signed [WIDTH-1:0] cur;
  logic [1:0]              count_after_pop;

  assign s_ready_y    = !reset && (count_q < 2'd2);
  assign m_valid_z    = (count_q != 2'd0);
  assign m_data_out_z = fifo_data_q[0];
  assign m_last_z     = fifo_last_q[0];

  always_comb begin
    accept    = s_valid_y && s_ready_y;
    pop       = m_valid_z && m_ready_z;
    vec_end   = (in_cnt_q == LastIdx);
    win_close = (win_cnt_q == WinLast) || vec_end;
    push      = accept && win_close;
    cur       = ((win_cnt_q == '0) || (s_data_in_y > max_q)) ? s_data_in_y : max_q;

    in_cnt_d  = in_cnt_q;
    win_cnt_d = win_cnt_q;
    max_d     = max_q;
    if (accept) begin
      max_d     = cur;
      in_cnt_d  = vec_end ? '0 : in_cnt_q + LOGLEN'(1);
      win_cnt_d = win_close ? '0 : win_cnt_q + LOGLEN'(1);
    end

    // Head always lives in slot 0; a pop shifts slot 1 forward before any push lands.
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    count_after_pop = pop ? count_q - 2'd1 : count_q;
    if (push) begin
      if (count_after_pop == 2'd0) begin
        fifo_data_d[0] = cur;
        fifo_last_d[0] = vec_end;
      end else begin
        fifo_data_d[1] = cur;
        fifo_last_d[1] = vec_end;
      end
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q       <= '0;
      win_cnt_q      <= '0;
      max_q          <= '0;
      count_q        <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      win_cnt_q   <= win_cnt_d;
      max_q       <= max_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: three instances (POOLW 2, 1, LEN) share stimulus and are each
// tracked by a window/queue reference model, plus directed table and corner sequences.
module tb_maxpool_stream;
  localparam int W   = 8;
  localparam int LEN = 5;
  localparam int NI  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, s_valid, m_ready;
  logic signed [W-1:0] s_data;
  logic                sr [NI];
  logic                mv [NI];
  logic                ml [NI];
  logic signed [W-1:0] md [NI];

  maxpool_stream #(.WIDTH(W), .LEN(LEN), .POOLW(2), .LOGLEN(3)) u_dut (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(sr[0]),
    .m_data_out_z(md[0]), .m_valid_z(mv[0]), .m_ready_z(m_ready), .m_last_z(ml[0]));
  maxpool_stream #(.WIDTH(W), .LEN(LEN), .POOLW(1), .LOGLEN(3)) u_dut_p1 (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(sr[1]),
    .m_data_out_z(md[1]), .m_valid_z(mv[1]), .m_ready_z(m_ready), .m_last_z(ml[1]));
  maxpool_stream #(.WIDTH(W), .LEN(LEN), .POOLW(LEN), .LOGLEN(3)) u_dut_p5 (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(sr[2]),
    .m_data_out_z(md[2]), .m_valid_z(mv[2]), .m_ready_z(m_ready), .m_last_z(ml[2]));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: samples of the open window and the expected output buffer.
  int                  in_idx [NI];
  int                  win_n  [NI];
  logic signed [W-1:0] win_buf [NI][LEN];
  int                  ef_n   [NI];
  logic signed [W-1:0] ef_d   [NI][4];
  logic                ef_l   [NI][4];

  logic signed [W-1:0] got_d [NI][64];
  logic                got_l [NI][64];
  int                  got_n [NI];
  logic                acc0;

  typedef struct {
    logic signed [W-1:0] in  [5];
    logic signed [W-1:0] exp [3];
    logic signed [W-1:0] vmax;
  } vec_t;
  vec_t tbl [4];

  function automatic int pw_of(int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return LEN;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      in_idx[i] = 0;
      win_n[i]  = 0;
      ef_n[i]   = 0;
    end
  endtask

  task automatic model_accept(int i, logic signed [W-1:0] x);
    logic signed [W-1:0] mx;
    win_buf[i][win_n[i]] = x;
    win_n[i]++;
    in_idx[i]++;
    if (win_n[i] == pw_of(i) || in_idx[i] == LEN) begin
      mx = win_buf[i][0];
      for (int k = 1; k < win_n[i]; k++) if (win_buf[i][k] > mx) mx = win_buf[i][k];
      ef_d[i][ef_n[i]] = mx;
      ef_l[i][ef_n[i]] = (in_idx[i] == LEN);
      ef_n[i]++;
      win_n[i] = 0;
      if (in_idx[i] == LEN) in_idx[i] = 0;
    end
  endtask

  task automatic clear_got();
    for (int i = 0; i < NI; i++) got_n[i] = 0;
  endtask

  // One clock: check every instance against the model, capture pops, advance the model.
  task automatic cycle();
    @(negedge clk);
    acc0 = s_valid && sr[0];
    for (int i = 0; i < NI; i++) begin
      check($sformatf("s_ready[%0d]", i), int'(sr[i]), (!reset && ef_n[i] < 2) ? 1 : 0);
      check($sformatf("m_valid[%0d]", i), int'(mv[i]), (ef_n[i] != 0) ? 1 : 0);
      if (ef_n[i] != 0) begin
        check($sformatf("m_data[%0d]", i), int'(md[i]), int'(ef_d[i][0]));
        check($sformatf("m_last[%0d]", i), int'(ml[i]), int'(ef_l[i][0]));
      end
      if (mv[i] && m_ready && got_n[i] < 64) begin
        got_d[i][got_n[i]] = md[i];
        got_l[i][got_n[i]] = ml[i];
        got_n[i]++;
      end
    end
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        logic acc;
        acc = s_valid && (ef_n[i] < 2);
        if (m_ready && ef_n[i] > 0) begin
          ef_d[i][0] = ef_d[i][1];
          ef_l[i][0] = ef_l[i][1];
          ef_d[i][1] = ef_d[i][2];
          ef_l[i][1] = ef_l[i][2];
          ef_n[i]--;
        end
        if (acc) model_accept(i, s_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(logic signed [W-1:0] x);
    s_valid = 1'b1;
    s_data  = x;
    cycle();
    s_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int t;
    logic signed [W-1:0] bp [5];

    tbl[0].in  = '{8'sd3, 8'sd7, 8'sd2, 8'sd2, 8'sd9};
    tbl[0].exp = '{8'sd7, 8'sd2, 8'sd9};
    tbl[0].vmax = 8'sd9;
    tbl[1].in  = '{-8'sd5, -8'sd3, 8'sh80, 8'sd127, 8'sd0};
    tbl[1].exp = '{-8'sd3, 8'sd127, 8'sd0};
    tbl[1].vmax = 8'sd127;
    tbl[2].in  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    tbl[2].exp = '{8'sd2, 8'sd4, 8'sd5};
    tbl[2].vmax = 8'sd5;
    tbl[3].in  = '{8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1};
    tbl[3].exp = '{8'sd5, 8'sd3, 8'sd1};
    tbl[3].vmax = 8'sd5;
    bp = '{8'sd3, 8'sd7, 8'sd2, 8'sd2, 8'sd9};

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    model_reset();
    clear_got();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("reset_data", int'(md[0]), 0);
    check("reset_last", int'(ml[0]), 0);
    reset = 1'b0;

    // Table vectors streamed back-to-back with the sink always ready.
    m_ready = 1'b1;
    clear_got();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 5; k++) begin
        s_valid = 1'b1;
        s_data  = tbl[r].in[k];
        cycle();
      end
    s_valid = 1'b0;
    repeat (3) cycle();
    check("tbl_count_p2", got_n[0], 12);
    check("tbl_count_p1", got_n[1], 20);
    check("tbl_count_p5", got_n[2], 4);
    idx = 0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 3; j++) begin
        check($sformatf("tbl%0d_p2_data%0d", r, j), int'(got_d[0][idx]), int'(tbl[r].exp[j]));
        check($sformatf("tbl%0d_p2_last%0d", r, j), int'(got_l[0][idx]), (j == 2) ? 1 : 0);
        idx++;
      end
    idx = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 5; k++) begin
        check($sformatf("tbl%0d_p1_data%0d", r, k), int'(got_d[1][idx]), int'(tbl[r].in[k]));
        check($sformatf("tbl%0d_p1_last%0d", r, k), int'(got_l[1][idx]), (k == 4) ? 1 : 0);
        idx++;
      end
    for (int r = 0; r < 4; r++) begin
      check($sformatf("tbl%0d_p5_data", r), int'(got_d[2][r]), int'(tbl[r].vmax));
      check($sformatf("tbl%0d_p5_last", r), int'(got_l[2][r]), 1);
    end

    // Backpressure: two results buffer, fifth sample is held off.
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      feed(bp[k]);
      check($sformatf("bp_accept%0d", k), int'(acc0), 1);
    end
    s_valid = 1'b1;
    s_data  = bp[4];
    repeat (3) begin
      cycle();
      check("bp_held", int'(acc0), 0);
    end
    check("bp_ready_low", int'(sr[0]), 0);
    check("bp_head", int'(md[0]), 7);
    clear_got();
    m_ready = 1'b1;
    t = 0;
    while (got_n[0] < 3 && t < 20) begin
      cycle();
      if (acc0) s_valid = 1'b0;
      t++;
    end
    s_valid = 1'b0;
    repeat (3) cycle();
    check("bp_count", got_n[0], 3);
    check("bp_out0", int'(got_d[0][0]), 7);
    check("bp_out1", int'(got_d[0][1]), 2);
    check("bp_out2", int'(got_d[0][2]), 9);
    check("bp_last", int'(got_l[0][2]), 1);

    // Reset mid-vector with a result buffered.
    m_ready = 1'b0;
    feed(8'sd3);
    feed(8'sd7);
    feed(8'sd2);
    check("pre_reset_valid", int'(mv[0]), 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("post_reset_valid", int'(mv[0]), 0);
    clear_got();
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) feed(8'sd1);
    repeat (3) cycle();
    check("rst_count", got_n[0], 3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_out%0d", j), int'(got_d[0][j]), 1);
      check($sformatf("rst_last%0d", j), int'(got_l[0][j]), (j == 2) ? 1 : 0);
    end

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = W'($urandom);
      reset   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming 1-D max-pooling stage placed directly downstream of the convolution layer. It consumes the layer's output vector (LEN signed samples per vector) over a valid/ready handshake, reduces each non-overlapping window of POOLW consecutive samples to its maximum, and emits the pooled vector (ceil(LEN/POOLW) samples) over a second valid/ready handshake. A 2-entry output buffer provides full throughput and isolates input readiness from output backpressure.

## Interface

Parameters:
- WIDTH, 8, sample width (signed two's complement), same as the conv layer's WIDTH.
- LEN, 5, input samples per vector (conv output length N-M+1); LEN >= 1.
- POOLW, 2, pooling window and stride; 1 <= POOLW <= LEN.
- LOGLEN, 3, counter width, 2**LOGLEN >= LEN.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_data_in_y  input  WIDTH  signed input sample.
- s_valid_y  input  1  input sample valid.
- s_ready_y  output  1  block can accept a sample.
- m_data_out_z  output  WIDTH  signed pooled sample (buffer head).
- m_valid_z  output  1  m_data_out_z valid.
- m_ready_z  input  1  downstream accepts the head.
- m_last_z  output  1  head is the final pooled sample of its vector.

## Operation

- Accept = s_valid_y && s_ready_y; pop = m_valid_z && m_ready_z.
- State: in_cnt (0..LEN-1), win_cnt (0..POOLW-1), max_reg (WIDTH, signed), 2-entry FIFO of {data, last}, count (0..2).
- On accept, cur = (win_cnt == 0) ? s_data_in_y : signed max(max_reg, s_data_in_y); max_reg <= cur.
- Window closes on accept when win_cnt == POOLW-1 or in_cnt == LEN-1 (trailing partial window is pooled over the samples it has). On close: push {cur, in_cnt == LEN-1}; win_cnt <= 0. Otherwise win_cnt <= win_cnt+1.
- in_cnt increments per accept, wraps LEN-1 -> 0; win_cnt also forced to 0 at wrap. Vectors stream back-to-back with no gap required.
- Comparison is signed; ties keep either value (identical). No arithmetic beyond compare; no saturation needed.
- s_ready_y = !reset && (count < 2). Depends only on registered state; no combinational path from m_ready_z.
- m_valid_z = (count != 0); m_data_out_z/m_last_z = FIFO head.
- Simultaneous push and pop: count unchanged, pushed entry queued behind remaining entry (or becomes head if count was 1). Push at count 2 cannot occur (s_ready_y low).
- Input arriving while s_ready_y low is ignored (not consumed); upstream holds it.

## Timing

- Reset (sampled high at a rising edge): in_cnt, win_cnt, max_reg, count <= 0; FIFO data <= 0; outputs after that edge: m_valid_z 0, m_data_out_z 0, m_last_z 0; s_ready_y 0 while reset is high.
- Reset mid-vector discards partial window, counters, and buffered outputs; first sample accepted after reset is sample 0 of a new vector.
- Latency: sample that closes a window accepted at edge k -> pooled result on m_data_out_z with m_valid_z high after edge k (visible cycle k+1) if buffer was empty.
- Throughput: one input per cycle sustained while m_ready_z held high; one output per POOLW inputs (plus one per partial trailing window).
- Backpressure: with m_ready_z low, at most 2 pooled results buffer; s_ready_y drops the cycle after count reaches 2 and rises the cycle after a pop.
- m_data_out_z/m_last_z stable while m_valid_z high and m_ready_z low.

## Test plan

- LEN=5, POOLW=2, m_ready_z=1, inputs 3,7,2,2,9 back-to-back -> outputs 7,2,9; m_last_z high only with 9; each output one cycle after its closing input.
- Signed compare: LEN=5, POOLW=2, inputs -5,-3,-128,127,0 -> outputs -3,127,0.
- Backpressure: m_ready_z=0, stream 3,7,2,2,9 -> buffer holds 7,2, s_ready_y low after 4th sample, sample 9 held; raise m_ready_z -> 7,2,9 in order, none lost or duplicated.
- Two consecutive vectors 1,2,3,4,5 then 5,4,3,2,1 with no gap -> 2,4,5(last),5,3,1(last); window counter restarts at vector boundary.
- POOLW=1 (LEN=5) -> pass-through, 1-cycle latency, m_last_z on 5th sample; POOLW=LEN -> single output = vector max with m_last_z.
- Reset asserted after 3 samples of 3,7,2 with 7 buffered and m_ready_z=0 -> m_valid_z 0, count 0; then 1,1,1,1,1 -> outputs 1,1,1(last).
